// File: rtl/mm_lsu.sv
// mm_lsu: memory stage that splits loads/stores into controller beats and assembles load results.
module mm_lsu #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [XLEN-1:0]   wn,
  input  logic [XLEN-1:0]   mm_mem_n,
  input  logic [4:0]        mm_mem_e,
  output logic              we_o,
  output logic [RA_W-1:0]   wa_o,
  output logic [XLEN-1:0]   wn_o,
  output logic [XLEN-1:0]   mm_mct_a,
  output logic [BEAT_W-1:0] mm_mct_n_i,
  input  logic [BEAT_W-1:0] mm_mct_n_o,
  output logic              mm_mct_wr,
  output logic              mm_mct_e,
  output logic [1:0]        mm_mct_cu,
  input  logic              mm_mct_ok,
  output logic              stl,
  output logic              busy
);
  localparam int BEAT_B = BEAT_W / 8;
  localparam logic [1:0] BCU = BEAT_W == 32 ? 2'd3 : BEAT_W == 16 ? 2'd1 : 2'd0;
  typedef enum logic {IDLE, ACC} st_t;
  st_t st, st_n;
  logic [2:0] k, sb, nb;
  logic [XLEN-1:0] la, lsd, asm_q, asm_n, ld;
  logic [1:0] lsz;
  logic lst, lun, lwe, acc, start, done;
  logic [RA_W-1:0] lwa;
  always_comb begin
    sb    = lsz == 2'd3 ? 3'd4 : lsz == 2'd1 ? 3'd2 : 3'd1;
    nb    = sb > 3'(BEAT_B) ? sb / 3'(BEAT_B) : 3'd1;
    acc   = st == ACC;
    start = !acc && mm_mem_e[4];
    done  = acc && mm_mct_ok && k == nb - 3'd1;
    asm_n = asm_q | (XLEN'(mm_mct_n_o) << (int'(k) * BEAT_W));
    ld    = sb == 3'd4 ? asm_n
          : sb == 3'd2 ? {{(XLEN-16){asm_n[15] & ~lun}}, asm_n[15:0]}
          : {{(XLEN-8){asm_n[7] & ~lun}}, asm_n[7:0]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= st_n;
  always_comb st_n = start ? ACC : done ? IDLE : st;
  // stl drops in the completing cycle so upstream advances on the same edge
  always_comb begin
    stl        = rst && (start || (acc && !done));
    busy       = acc;
    mm_mct_e   = acc;
    mm_mct_wr  = acc && lst;
    mm_mct_a   = acc ? la + XLEN'(int'(k) * BEAT_B) : '0;
    mm_mct_n_i = acc ? BEAT_W'(lsd >> (int'(k) * BEAT_W)) : '0;
    mm_mct_cu  = acc ? (sb <= 3'(BEAT_B) ? lsz : BCU) : 2'd0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      k     <= '0;
      la    <= '0;
      lsd   <= '0;
      lsz   <= '0;
      lst   <= 1'b0;
      lun   <= 1'b0;
      lwe   <= 1'b0;
      lwa   <= '0;
      asm_q <= '0;
      we_o  <= 1'b0;
      wa_o  <= '0;
      wn_o  <= '0;
    end else if (!acc) begin
      if (start) begin
        la    <= wn;
        lsd   <= mm_mem_n;
        lsz   <= mm_mem_e[3:2];
        lst   <= mm_mem_e[1];
        lun   <= mm_mem_e[0];
        lwe   <= we;
        lwa   <= wa;
        k     <= '0;
        asm_q <= '0;
        we_o  <= 1'b0;
      end else begin
        we_o <= we;
        wa_o <= wa;
        wn_o <= wn;
      end
    end else begin
      we_o <= done && !lst && lwe;
      if (mm_mct_ok) begin
        k     <= k + 3'd1;
        asm_q <= asm_n;
      end
      if (done) begin
        wa_o <= lwa;
        wn_o <= lst ? '0 : ld;
      end
    end
endmodule

// File: doc/mm_lsu.md
MM_LSU -- requirements
Module: mm_lsu

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 Parameter BEAT_W, default 8, memory-controller data width per beat; legal values 8, 16, 32; BEAT_B = BEAT_W/8.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 we, wa, wn  in  1/RA_W/XLEN  writeback enable, register address, ALU result (memory address for memory ops).
REQ-008 mm_mem_n  in  XLEN  store data.
REQ-009 mm_mem_e  in  5  [4] memory op, [3:2] size (3 word, 1 half, other byte), [1] store, [0] unsigned load.
REQ-010 we_o, wa_o, wn_o  out  1/RA_W/XLEN  registered writeback to next stage.
REQ-011 mm_mct_a  out  XLEN  beat byte address.
REQ-012 mm_mct_n_i  out  BEAT_W  beat write data.
REQ-013 mm_mct_n_o  in  BEAT_W  beat read data, right-justified.
REQ-014 mm_mct_wr, mm_mct_e  out  1  write select, request.
REQ-015 mm_mct_cu  out  2  size of current beat, same encoding as mm_mem_e[3:2].
REQ-016 mm_mct_ok  in  1  beat-complete strobe from controller.
REQ-017 stl  out  1  stall request to upstream stages.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 States: IDLE, ACC; a state register, beat counter, latched op (address, store data, size, store, unsigned, we, wa) and a load-assembly register.
REQ-020 IDLE, mm_mem_e[4]=0: each edge registers we_o<=we, wa_o<=wa, wn_o<=wn (1-cycle latency); stl=0.
REQ-021 IDLE, mm_mem_e[4]=1: stl=1 combinationally; on the edge latch op, clear beat counter, go ACC, register we_o<=0.
REQ-022 Access bytes S: 4 (word), 2 (half), 1 (byte); beats N = max(1, S/BEAT_B).
REQ-023 ACC: mm_mct_e=1, mm_mct_a = latched address + k*BEAT_B for beat k, mm_mct_wr = latched store, mm_mct_cu = latched size if S<=BEAT_B else beat size code, mm_mct_n_i = store-data bits [k*BEAT_W +: BEAT_W]; all held stable until mm_mct_ok sampled high.
REQ-024 A beat completes on an edge where mm_mct_e=1 and mm_mct_ok=1; load beat data stored to assembly bits [k*BEAT_W +: BEAT_W]; k increments.
REQ-025 stl=1 throughout ACC except in the cycle mm_mct_ok=1 on beat N-1, where stl=0 so upstream advances on the completing edge.
REQ-026 Completing edge, load: we_o<=latched we, wa_o<=latched wa, wn_o<=assembled S bytes, sign-extended from bit 8*S-1 unless unsigned (word: no extension); state->IDLE.
REQ-027 Completing edge, store: we_o<=0, wn_o<=0, wa_o<=latched wa; state->IDLE.
REQ-028 Non-final ACC cycles register we_o<=0 (bubble).
REQ-029 mm_mct_ok while mm_mct_e=0 is ignored.
REQ-030 Inputs are ignored during ACC; the op latched in IDLE is used.
REQ-031 Outside ACC, mm_mct_e=0, mm_mct_wr=0; mm_mct_a, mm_mct_n_i, mm_mct_cu drive 0.
REQ-032 Address alignment is not checked; beat addresses are computed modulo 2^XLEN.

Reset
REQ-033 rst=0 forces immediately: state IDLE, counter 0, we_o=0, wa_o=0, wn_o=0, mm_mct_e=0, mm_mct_wr=0, stl=0, busy=0.
REQ-034 Reset during ACC abandons the access; no writeback occurs; the first op after rst release starts from beat 0.

Verification
REQ-035 ALU op we=1 wa=5 wn=0x1234, mem_e=0 -> next edge we_o=1 wa_o=5 wn_o=0x1234, stl=0.
REQ-036 BEAT_W=8, signed byte load at 0x100, ok after 2 wait cycles, n_o=0x80 -> stl high 3 cycles, wn_o=0xFFFFFF80, we_o=1.
REQ-037 BEAT_W=8, word load at 0x200, bytes 0x11,0x22,0x33,0x44 -> mct_a 0x200..0x203 in order, wn_o=0x44332211.
REQ-038 BEAT_W=16, word store 0xAABBCCDD at 0x40 -> beats (0x40,0xCCDD),(0x42,0xAABB), mct_wr=1, we_o=0 on completion.
REQ-039 BEAT_W=8, unsigned half load 0xFF,0xFF -> wn_o=0x0000FFFF; signed -> 0xFFFFFFFF.
REQ-040 rst asserted mid-word-load after beat 1 -> mct_e and stl drop immediately, we_o=0; next load completes correctly from beat 0.
